freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Measures a slow square wave (e.g. a divider's fout, an external tick) against the
//  fin system clock (50 MHz on board). Reports period and high time in fin cycles.
//  Asserts a one-cycle valid strobe per completed period and flags a dead or stuck input.
//  Serves as the in-system checker for divider outputs that drive the LED and 7-seg logic.
// PARAMETERS
//  CNT_W    32              width of period/high_cnt and internal counters
//  TIMEOUT  32'd100000000   fin cycles without a rising edge before timeout (2 s @ 50 MHz);
//                           must be >= 2 and < 2**CNT_W-1
// PORTS
//  fin         in   1      system clock; all logic on posedge fin
//  reset       in   1      synchronous, active-high reset
//  sig_in      in   1      measured signal, asynchronous to fin
//  period      out  CNT_W  fin cycles between the last two sig_in rising edges
//  high_cnt    out  CNT_W  fin cycles sig_in was high within that period
//  meas_valid  out  1      1-cycle pulse when period/high_cnt update
//  locked      out  1      1 while periodic edges are being measured
//  timeout     out  1      sticky; set on timeout, cleared by next meas_valid or reset
// BEHAVIOUR
//  Reset (reset=1 at posedge fin):
//   - all outputs clear to 0; s1/s2/s3 clear to 0; cnt=0, hcnt=0; state=WAIT.
//   - Reset has priority over every other event, including mid-measurement.
//  Synchronizer and edge detect:
//   - s1<=sig_in, s2<=s1, s3<=s2.
//   - rise = s2&~s3 (combinational). rise is seen 2 fin edges after sig_in rises.
//   - Pulses shorter than 1 fin cycle may be missed. This is not an error.
//  FSM WAIT (arming):
//   - Entered after reset or timeout.
//   - On rise: go to RUN, cnt<=1, hcnt<=1. No meas_valid.
//   - The first edge after reset only arms, so a spurious edge from the 0-cleared
//     synchronizer never yields a measurement.
//  FSM RUN:
//   - Each cycle without rise: cnt<=cnt+1, and hcnt<=hcnt+s2.
//   - On rise, in one cycle:
//       period<=cnt, high_cnt<=hcnt, meas_valid<=1, locked<=1, timeout<=0;
//       cnt<=1, hcnt<=1; stay in RUN.
//     The rise cycle is the first cycle of the new period.
//   - Timeout: when cnt==TIMEOUT and no rise, go to WAIT.
//       timeout<=1, locked<=0, cnt<=0, hcnt<=0.
//       period/high_cnt hold their last values.
//   - If rise occurs in the same cycle as cnt==TIMEOUT, rise wins:
//       normal measurement with period=TIMEOUT, no timeout.
//  Counter and output rules:
//   - cnt never exceeds TIMEOUT, so it never wraps.
//   - Invariant: 1 <= high_cnt <= period on every meas_valid.
//   - meas_valid is high for exactly 1 cycle; it is 0 in every other cycle.
//   - An input stuck high or stuck low produces a timeout. locked stays 0 until 2 new rises.
// TESTING
//  1. sig_in = divider output with Divn=4, fin-synchronous, after reset.
//     -> 1st rise arms only; then meas_valid every 4 cycles with period=4, high_cnt=2.
//  2. sig_in with Divn=2000.
//     -> period=2000, high_cnt=1000 each period; locked=1; timeout=0.
//  3. TIMEOUT=100, sig_in held 0 after 3 good periods of 10.
//     -> timeout=1 and locked=0 exactly 100 cycles after the last rise.
//     -> period stays 10; edges resumed later: 1st rise arms only, 2nd gives meas_valid
//        and clears timeout.
//  4. TIMEOUT=100, rising edges exactly 100 cycles apart.
//     -> meas_valid with period=100 every time; timeout never set.
//  5. reset pulsed for 1 cycle mid-period while locked.
//     -> next cycle all outputs 0, state WAIT; the following 2 rises give a single
//        correct measurement.
//  6. sig_in high during and after reset.
//     -> the spurious s2 rise only arms; no meas_valid until the next real rising edge.

Source files
------------

// File: rtl/freq_meter.sv
// Period and high-time meter for a slow square wave sampled on fin.
// Emits one strobe per completed period and flags a dead or stuck input.
module freq_meter #(
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(100_000_000)
) (
    input  logic             fin,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;

    logic             w_rise;
    logic             w_arm;
    logic             w_meas;
    logic             w_tmo;

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge fin) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise coinciding with cnt==TIMEOUT is a valid period, not a timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_meas      = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            S_WAIT: begin
                if (w_rise) begin
                    w_state_nxt = S_RUN;
                    w_arm       = 1'b1;
                end
            end
            S_RUN: begin
                if (w_rise) begin
                    w_meas = 1'b1;
                end else if (r_cnt == TIMEOUT) begin
                    w_state_nxt = S_WAIT;
                    w_tmo       = 1'b1;
                end
            end
            default: w_state_nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge fin) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_s1    <= sig_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= w_meas;

            // The rise cycle is the first cycle of the new period.
            if (w_arm || w_meas) begin
                r_cnt  <= CNT_W'(1);
                r_hcnt <= CNT_W'(1);
            end else if (w_tmo) begin
                r_cnt  <= '0;
                r_hcnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_hcnt <= r_hcnt + CNT_W'(r_s2);
            end

            if (w_meas) begin
                r_period  <= r_cnt;
                r_high    <= r_hcnt;
                r_locked  <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_tmo) begin
                r_locked  <= 1'b0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign period     = r_period;
    assign high_cnt   = r_high;
    assign meas_valid = r_valid;
    assign locked     = r_locked;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (long and short timeout)
// with a per-instance scoreboard of expected period/high_cnt pairs.
module tb_freq_meter;

    localparam int CW = 32;

    logic          fin;
    logic          reset;
    logic          sig_a;
    logic          sig_b;
    logic [CW-1:0] period_a;
    logic [CW-1:0] high_a;
    logic          valid_a;
    logic          locked_a;
    logic          tmo_a;
    logic [CW-1:0] period_b;
    logic [CW-1:0] high_b;
    logic          valid_b;
    logic          locked_b;
    logic          tmo_b;

    int n_pass  = 0;
    int n_total = 0;
    int tmo_cyc_b = 0;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    freq_meter #(.CNT_W(CW), .TIMEOUT(32'd5000)) dut_a (
        .fin        (fin),
        .reset      (reset),
        .sig_in     (sig_a),
        .period     (period_a),
        .high_cnt   (high_a),
        .meas_valid (valid_a),
        .locked     (locked_a),
        .timeout    (tmo_a)
    );

    freq_meter #(.CNT_W(CW), .TIMEOUT(32'd100)) dut_b (
        .fin        (fin),
        .reset      (reset),
        .sig_in     (sig_b),
        .period     (period_b),
        .high_cnt   (high_b),
        .meas_valid (valid_b),
        .locked     (locked_b),
        .timeout    (tmo_b)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    always @(negedge fin) begin
        if (tmo_b === 1'b1) tmo_cyc_b++;
    end

    always @(negedge fin) begin
        exp_t e;
        if (valid_a === 1'b1) begin
            chk("a_unexpected_valid", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_period", period_a, e.per);
                chk("a_high", high_a, e.hi);
                chk("a_locked_at_meas", locked_a, 1);
                chk("a_tmo_at_meas", tmo_a, 0);
            end
        end
    end

    always @(negedge fin) begin
        exp_t e;
        if (valid_b === 1'b1) begin
            chk("b_unexpected_valid", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_period", period_b, e.per);
                chk("b_high", high_b, e.hi);
                chk("b_locked_at_meas", locked_b, 1);
                chk("b_tmo_at_meas", tmo_b, 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge fin);
        reset = 1'b1;
        repeat (2) @(negedge fin);
        reset = 1'b0;
    endtask

    task automatic push(input bit b, input int per, input int hi, input int n);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        for (int i = 0; i < n; i++) begin
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
    endtask

    task automatic wave(input bit b, input int n, input int hi, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < n; i++) begin
                @(negedge fin);
                if (b) sig_b = (i < hi);
                else   sig_a = (i < hi);
            end
        end
    endtask

    initial begin
        int tmo_snap;
        reset = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;

        // Reset state
        do_reset();
        chk("rst_period_a", period_a, 0);
        chk("rst_high_a", high_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_locked_a", locked_a, 0);
        chk("rst_tmo_a", tmo_a, 0);
        chk("rst_period_b", period_b, 0);
        chk("rst_locked_b", locked_b, 0);
        chk("rst_tmo_b", tmo_b, 0);

        // Divide-by-4: first rise arms only
        push(1'b0, 4, 2, 5);
        wave(1'b0, 4, 2, 6);
        repeat (5) @(negedge fin);
        chk("t1_queue_empty", qa.size(), 0);
        chk("t1_period_hold", period_a, 4);
        chk("t1_locked", locked_a, 1);

        // Divide-by-2000
        do_reset();
        push(1'b0, 2000, 1000, 3);
        wave(1'b0, 2000, 1000, 4);
        chk("t2_queue_empty", qa.size(), 0);
        chk("t2_locked", locked_a, 1);
        chk("t2_tmo", tmo_a, 0);

        // Timeout 100 cycles after the last rise
        do_reset();
        push(1'b1, 10, 5, 3);
        wave(1'b1, 10, 5, 3);
        @(negedge fin);
        sig_b = 1'b1;
        for (int k = 1; k <= 102; k++) begin
            @(negedge fin);
            if (k == 5) sig_b = 1'b0;
        end
        chk("t3_queue_empty", qb.size(), 0);
        chk("t3_tmo_before", tmo_b, 0);
        chk("t3_locked_before", locked_b, 1);
        @(negedge fin);
        chk("t3_tmo_set", tmo_b, 1);
        chk("t3_locked_clr", locked_b, 0);
        chk("t3_period_hold", period_b, 10);
        chk("t3_high_hold", high_b, 5);
        wave(1'b1, 10, 5, 1);
        chk("t3_arm_tmo_kept", tmo_b, 1);
        chk("t3_arm_locked", locked_b, 0);
        push(1'b1, 10, 5, 1);
        wave(1'b1, 10, 5, 1);
        chk("t3_resume_empty", qb.size(), 0);
        chk("t3_tmo_cleared", tmo_b, 0);
        chk("t3_relocked", locked_b, 1);

        // Rises exactly TIMEOUT apart: rise wins
        do_reset();
        tmo_snap = tmo_cyc_b;
        push(1'b1, 100, 50, 4);
        wave(1'b1, 100, 50, 5);
        chk("t4_queue_empty", qb.size(), 0);
        chk("t4_no_timeout", tmo_cyc_b - tmo_snap, 0);
        chk("t4_locked", locked_b, 1);

        // One-cycle reset mid-period while locked
        do_reset();
        push(1'b0, 10, 5, 3);
        wave(1'b0, 10, 5, 3);
        @(negedge fin);
        sig_a = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge fin);
            if (k == 5) sig_a = 1'b0;
        end
        chk("t5_pre_empty", qa.size(), 0);
        chk("t5_pre_locked", locked_a, 1);
        reset = 1'b1;
        @(negedge fin);
        reset = 1'b0;
        chk("t5_period_0", period_a, 0);
        chk("t5_high_0", high_a, 0);
        chk("t5_valid_0", valid_a, 0);
        chk("t5_locked_0", locked_a, 0);
        chk("t5_tmo_0", tmo_a, 0);
        push(1'b0, 10, 5, 1);
        wave(1'b0, 10, 5, 2);
        chk("t5_post_empty", qa.size(), 0);
        chk("t5_post_locked", locked_a, 1);

        // Input high through reset: spurious rise only arms
        @(negedge fin);
        sig_a = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge fin);
        reset = 1'b0;
        repeat (20) @(negedge fin);
        sig_a = 1'b0;
        chk("t6_no_lock", locked_a, 0);
        chk("t6_no_meas", period_a, 0);
        push(1'b0, 21, 20, 1);
        push(1'b0, 8, 3, 2);
        wave(1'b0, 8, 3, 3);
        repeat (4) @(negedge fin);
        chk("t6_queue_empty", qa.size(), 0);
        chk("t6_locked", locked_a, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
